inst_fetch_q: RTL and testbench
===============================

INST_FETCH_Q -- requirements
Module: inst_fetch_q

Interface
REQ-001 Parameter ADDR_W, default 6, word-address bits; memory holds 2^ADDR_W 32-bit words.
REQ-002 Parameter QDEPTH, default 4, fetch-queue entries; power of two, at least 2.
REQ-003 Parameter RESET_PC, default 32'h0000_0000, byte PC loaded at reset; bits [1:0] SHALL be zero.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset; asynchronous and active-high.
REQ-006 wr_en / wr_addr / wr_data  input  1 / ADDR_W / 32  memory load port (word address).
REQ-007 redirect / redirect_pc  input  1 / 32  flush queue and restart fetch at redirect_pc.
REQ-008 out_ready  input  1  consumer accepts head entry.
REQ-009 out_valid  output  1  head entry present.
REQ-010 out_pc  output  32  byte PC of head entry.
REQ-011 opcode, r_reg1, r_reg2, w_reg, shift, funct  output  6,5,5,5,5,6  head word bits [31:26],[25:21],[20:16],[15:11],[10:6],[5:0].
REQ-012 inst_16bit  output  32  head word bits [15:0] sign-extended to 32 bits.
REQ-013 count  output  $clog2(QDEPTH)+1  queue occupancy.

Function
REQ-014 Fetch PC is a 32-bit register; memory index = pc[ADDR_W+1:2], so fetch wraps modulo 2^ADDR_W words while pc itself keeps incrementing by 4 modulo 2^32.
REQ-015 Push occurs on an edge when redirect=0 and (count<QDEPTH or pop); the pushed entry is {pc, mem[pc index]}, and pc advances by 4.
REQ-016 Pop occurs on an edge when out_valid=1, out_ready=1 and redirect=0.
REQ-017 Simultaneous push and pop at full SHALL be legal; count is unchanged.
REQ-018 out_valid = (count!=0); all decode outputs and out_pc SHALL be combinational from the head entry and SHALL be zero when the queue is empty.
REQ-019 Latency: the word at PC P SHALL be at the head one cycle after the edge on which fetch of P begins, when the queue was empty.
REQ-020 Redirect has priority: on an edge with redirect=1 the queue SHALL be emptied, no push or pop occurs, and pc <= {redirect_pc[31:2],2'b00}.
REQ-021 Memory write SHALL take effect on the edge; a fetch from the same index on that edge SHALL capture the old word (read-before-write).
REQ-022 Writes SHALL be accepted regardless of redirect, queue state or out_ready.
REQ-023 With out_ready held 0, fetch SHALL stop at count=QDEPTH and pc SHALL hold.

Reset
REQ-024 Asserting rst SHALL immediately force pc=RESET_PC, count=0, out_valid=0, all decode outputs and out_pc to zero, and the stall counter (if present) to zero.
REQ-025 Memory contents SHALL NOT be altered by reset; reset mid-stream discards queued entries.
REQ-026 The first push after rst deasserts SHALL occur on the first rising edge with rst low.

Configuration
REQ-027 Macro IFQ_STALL_CNT_EN defined: add output stall_cnt [31:0], incrementing (saturating at 2^32-1) on each edge where push was blocked because the queue was full and no pop occurred.
REQ-028 Macro IFQ_STALL_CNT_EN undefined: port stall_cnt and its counter SHALL NOT exist; all other behaviour identical.

Verification
REQ-029 Load mem[0..3]=32'h012A4020,32'h8C890004,32'h2108FFFF,32'h00000000; release reset, out_ready=1 -> cycle 1 head pc=0, opcode=0, r_reg1=9, r_reg2=10, w_reg=8, funct=6'h20; next pc=4 opcode=6'h23; pc=8 inst_16bit=32'hFFFFFFFF.
REQ-030 out_ready=0 from reset -> count reaches QDEPTH=4 after 4 edges, pc holds at 16, stall_cnt (if enabled) increments by 1 per further edge.
REQ-031 Full queue, out_ready=1 for one cycle -> exactly one pop and one push, count stays 4, next head pc=4.
REQ-032 redirect=1, redirect_pc=32'h0000_0023 with queue full and out_ready=1 -> next cycle count=0, out_valid=0; following cycle head out_pc=32'h20.
REQ-033 ADDR_W=2, start at pc=12 -> next fetched word is mem[0] with out_pc=16.
REQ-034 wr_en to index currently being fetched -> queued word equals old contents; refetch after redirect to same PC returns new contents; rst asserted mid-stream -> out_valid drops to 0 without a clock edge.

Source files
------------

// File: rtl/inst_fetch_q.sv
// Instruction fetch queue: word memory, free-running fetch PC and a small FIFO of decoded heads.
// Optional stall counter output enabled by defining IFQ_STALL_CNT_EN.
module inst_fetch_q #(
  parameter int          ADDR_W   = 6,
  parameter int          QDEPTH   = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [31:0]              wr_data,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [31:0]              out_pc,
  output logic [5:0]               opcode,
  output logic [4:0]               r_reg1,
  output logic [4:0]               r_reg2,
  output logic [4:0]               w_reg,
  output logic [4:0]               shift,
  output logic [5:0]               funct,
  output logic [31:0]              inst_16bit,
`ifdef IFQ_STALL_CNT_EN
  output logic [31:0]              stall_cnt,
`endif
  output logic [$clog2(QDEPTH):0] count
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(QDEPTH);

  logic [31:0]       r_mem    [2**ADDR_W];
  logic [31:0]       r_q_pc   [QDEPTH];
  logic [31:0]       r_q_word [QDEPTH];
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [CW-1:0]     r_count;
  logic [31:0]       r_pc;

  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic [ADDR_W-1:0] w_fetch_idx;
  logic [31:0]       w_head_word;
  logic [31:0]       w_head_pc;
  logic [31:0]       w_redirect_pc;

  // out_valid/out_ready: the head transfers on an edge where both are high and
  // redirect is low; out_valid depends only on occupancy, never on out_ready.
  assign w_full        = (r_count == FULL);
  assign out_valid     = (r_count != '0);
  assign w_pop         = out_valid && out_ready && !redirect;
  assign w_push        = !redirect && (!w_full || w_pop);
  assign w_fetch_idx   = r_pc[ADDR_W+1:2];
  assign w_redirect_pc = redirect_pc & 32'hFFFF_FFFC;

  // Memory is not reset; the fetch read sees the pre-write word on a colliding edge.
  always_ff @(posedge clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_pc[r_tail]   <= r_pc;
      r_q_word[r_tail] <= r_mem[w_fetch_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (redirect) begin
      r_pc    <= w_redirect_pc;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + PW'(1);
        r_pc   <= r_pc + 32'd4;
      end
      if (w_pop) r_head <= r_head + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef IFQ_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (!redirect && w_full && !w_pop && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

  // Head fields are masked so an empty queue presents all zeros.
  assign w_head_word = out_valid ? r_q_word[r_head] : 32'h0;
  assign w_head_pc   = out_valid ? r_q_pc[r_head]   : 32'h0;

  assign out_pc     = w_head_pc;
  assign opcode     = w_head_word[31:26];
  assign r_reg1     = w_head_word[25:21];
  assign r_reg2     = w_head_word[20:16];
  assign w_reg      = w_head_word[15:11];
  assign shift      = w_head_word[10:6];
  assign funct      = w_head_word[5:0];
  assign inst_16bit = {{16{w_head_word[15]}}, w_head_word[15:0]};
  assign count      = r_count;

endmodule

// File: tb/tb_inst_fetch_q.sv
// Directed bench for inst_fetch_q: vector table for fill/stall/redirect plus hand sequences.
module tb_inst_fetch_q;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [5:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [5:0]  opcode;
  logic [4:0]  r_reg1, r_reg2, w_reg, shift;
  logic [5:0]  funct;
  logic [31:0] inst_16bit;
  logic [2:0]  count;
`ifdef IFQ_STALL_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] stall_cnt2;
`endif

  // Second instance with a 4-word memory to exercise fetch-index wrap.
  logic        rst2 = 1'b1;
  logic        wr_en2 = 1'b0;
  logic [1:0]  wr_addr2 = '0;
  logic [31:0] wr_data2 = '0;
  logic        out_ready2 = 1'b0;
  logic        out_valid2;
  logic [31:0] out_pc2;
  logic [5:0]  opcode2;
  logic [4:0]  r_reg1_2, r_reg2_2, w_reg2, shift2;
  logic [5:0]  funct2;
  logic [31:0] inst_16bit2;
  logic [2:0]  count2;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_mem [64];

  inst_fetch_q dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .redirect(redirect), .redirect_pc(redirect_pc), .out_ready(out_ready),
    .out_valid(out_valid), .out_pc(out_pc), .opcode(opcode), .r_reg1(r_reg1),
    .r_reg2(r_reg2), .w_reg(w_reg), .shift(shift), .funct(funct),
    .inst_16bit(inst_16bit),
`ifdef IFQ_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .count(count)
  );

  inst_fetch_q #(.ADDR_W(2), .QDEPTH(4), .RESET_PC(32'd12)) dut2 (
    .clk(clk), .rst(rst2), .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
    .redirect(1'b0), .redirect_pc(32'h0), .out_ready(out_ready2),
    .out_valid(out_valid2), .out_pc(out_pc2), .opcode(opcode2), .r_reg1(r_reg1_2),
    .r_reg2(r_reg2_2), .w_reg(w_reg2), .shift(shift2), .funct(funct2),
    .inst_16bit(inst_16bit2),
`ifdef IFQ_STALL_CNT_EN
    .stall_cnt(stall_cnt2),
`endif
    .count(count2)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic [2:0]  exp_count;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_stall;
  } vec_t;

  vec_t vec [15];

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chk_head(input string nm, input logic [31:0] pc, input logic [31:0] word);
    chk({nm, ".valid"}, {31'h0, out_valid}, 32'd1);
    chk({nm, ".pc"}, out_pc, pc);
    chk({nm, ".fields"}, {opcode, r_reg1, r_reg2, w_reg, shift, funct}, word);
    chk({nm, ".imm"}, inst_16bit, {{16{word[15]}}, word[15:0]});
  endtask

  task automatic chk_empty(input string nm);
    chk({nm, ".valid"}, {31'h0, out_valid}, 32'd0);
    chk({nm, ".count"}, {29'h0, count}, 32'd0);
    chk({nm, ".pc"}, out_pc, 32'd0);
    chk({nm, ".fields"}, {opcode, r_reg1, r_reg2, w_reg, shift, funct}, 32'd0);
    chk({nm, ".imm"}, inst_16bit, 32'd0);
  endtask

  initial begin
    // Memory load while both instances sit in reset.
    for (int i = 0; i < 64; i++) exp_mem[i] = 32'h1000_0000 + i;
    exp_mem[0] = 32'h012A4020;
    exp_mem[1] = 32'h8C890004;
    exp_mem[2] = 32'h2108FFFF;
    exp_mem[3] = 32'h00000000;
    tick();
    for (int i = 0; i < 64; i++) begin
      wr_en = 1'b1; wr_addr = 6'(i); wr_data = exp_mem[i];
      wr_en2 = (i < 4); wr_addr2 = 2'(i); wr_data2 = 32'hA000_0000 + i;
      tick();
    end
    wr_en = 1'b0; wr_en2 = 1'b0;
    chk_empty("reset");
`ifdef IFQ_STALL_CNT_EN
    chk("reset.stall", stall_cnt, 32'd0);
`endif

    // Decode of the first three words with the consumer always ready.
    out_ready = 1'b1;
    rst = 1'b0;
    tick();
    chk("dec0.pc", out_pc, 32'h0);
    chk("dec0.opcode", {26'h0, opcode}, 32'h0);
    chk("dec0.r_reg1", {27'h0, r_reg1}, 32'd9);
    chk("dec0.r_reg2", {27'h0, r_reg2}, 32'd10);
    chk("dec0.w_reg", {27'h0, w_reg}, 32'd8);
    chk("dec0.shift", {27'h0, shift}, 32'd0);
    chk("dec0.funct", {26'h0, funct}, 32'h20);
    chk("dec0.count", {29'h0, count}, 32'd1);
    tick();
    chk("dec1.pc", out_pc, 32'h4);
    chk("dec1.opcode", {26'h0, opcode}, 32'h23);
    tick();
    chk("dec2.pc", out_pc, 32'h8);
    chk("dec2.imm", inst_16bit, 32'hFFFF_FFFF);

    // Write to the index fetched on the same edge: queue keeps the old word.
    wr_en = 1'b1; wr_addr = 6'd3; wr_data = 32'hDEAD_BEEF;
    tick();
    wr_en = 1'b0;
    chk_head("rbw_old", 32'hC, 32'h0000_0000);
    exp_mem[3] = 32'hDEAD_BEEF;
    redirect = 1'b1; redirect_pc = 32'hC;
    tick();
    redirect = 1'b0;
    chk_empty("rbw_flush");
    tick();
    chk_head("rbw_new", 32'hC, 32'hDEAD_BEEF);

    // Reset mid-stream takes effect without a clock edge; memory survives it.
    tick();
    rst = 1'b1;
    #1;
    chk_empty("async_rst");
    tick();
    out_ready = 1'b0;
    rst = 1'b0;
    tick();
    chk_head("post_rst", 32'h0, exp_mem[0]);
    chk("post_rst.count", {29'h0, count}, 32'd1);

    // Fresh reset, then fill / stall / single pop / redirect table.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vec[0]  = '{1'b0, 1'b0, 32'h0,  3'd1, 1'b1, 32'h0,   32'd0};
    vec[1]  = '{1'b0, 1'b0, 32'h0,  3'd2, 1'b1, 32'h0,   32'd0};
    vec[2]  = '{1'b0, 1'b0, 32'h0,  3'd3, 1'b1, 32'h0,   32'd0};
    vec[3]  = '{1'b0, 1'b0, 32'h0,  3'd4, 1'b1, 32'h0,   32'd0};
    vec[4]  = '{1'b0, 1'b0, 32'h0,  3'd4, 1'b1, 32'h0,   32'd1};
    vec[5]  = '{1'b0, 1'b0, 32'h0,  3'd4, 1'b1, 32'h0,   32'd2};
    vec[6]  = '{1'b1, 1'b0, 32'h0,  3'd4, 1'b1, 32'h4,   32'd2};
    vec[7]  = '{1'b0, 1'b0, 32'h0,  3'd4, 1'b1, 32'h4,   32'd3};
    vec[8]  = '{1'b1, 1'b1, 32'h23, 3'd0, 1'b0, 32'h0,   32'd3};
    vec[9]  = '{1'b0, 1'b0, 32'h0,  3'd1, 1'b1, 32'h20,  32'd3};
    vec[10] = '{1'b1, 1'b0, 32'h0,  3'd1, 1'b1, 32'h24,  32'd3};
    vec[11] = '{1'b1, 1'b0, 32'h0,  3'd1, 1'b1, 32'h28,  32'd3};
    vec[12] = '{1'b1, 1'b1, 32'hFE, 3'd0, 1'b0, 32'h0,   32'd3};
    vec[13] = '{1'b1, 1'b0, 32'h0,  3'd1, 1'b1, 32'hFC,  32'd3};
    vec[14] = '{1'b1, 1'b0, 32'h0,  3'd1, 1'b1, 32'h100, 32'd3};
    for (int v = 0; v < 15; v++) begin
      out_ready = vec[v].rdy; redirect = vec[v].redir; redirect_pc = vec[v].rpc;
      tick();
      chk($sformatf("vec%0d.count", v), {29'h0, count}, {29'h0, vec[v].exp_count});
      if (vec[v].exp_valid) chk_head($sformatf("vec%0d", v), vec[v].exp_pc, exp_mem[vec[v].exp_pc[7:2]]);
      else chk_empty($sformatf("vec%0d", v));
`ifdef IFQ_STALL_CNT_EN
      chk($sformatf("vec%0d.stall", v), stall_cnt, vec[v].exp_stall);
`endif
    end
    redirect = 1'b0; out_ready = 1'b0;

    // Four-word memory starting at pc 12: next fetch wraps to mem[0] at pc 16.
    out_ready2 = 1'b1;
    rst2 = 1'b0;
    tick();
    chk("wrap0.pc", out_pc2, 32'd12);
    chk("wrap0.imm", inst_16bit2, 32'h0000_0003);
    tick();
    chk("wrap1.pc", out_pc2, 32'd16);
    chk("wrap1.opcode", {26'h0, opcode2}, 32'h28);
    chk("wrap1.imm", inst_16bit2, 32'h0000_0000);
    chk("wrap1.count", {29'h0, count2}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
